// File: rtl/uart_rx_ctrl.sv
// UART receive sequencing and buffering controller: gates the receive core, queues bytes, tracks errors.
// Optional receive timeout is built when UART_RX_CTRL_TIMEOUT_EN is defined.
//
// state   | meaning
// S_OFF   | receiver disabled, core_rx_en low
// S_IDLE  | enabled, waiting for a frame to start
// S_RX    | frame in progress, held until the frame completes
// S_STALL | FIFO full, core held off until space frees
module uart_rx_ctrl #(
    parameter int DEPTH         = 16,
    parameter int AW            = 4,
    parameter bit STALL_ON_FULL = 1'b1
`ifdef UART_RX_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC   = 40000
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_en,
    input  logic          cfg_flush,
    input  logic [AW:0]   cfg_thresh,
    output logic          core_rx_en,
    input  logic          core_rx_busy,
    input  logic          core_rx_done,
    input  logic          core_rx_error,
    input  logic [7:0]    core_rx_data,
    input  logic          rd_req,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    output logic [AW:0]   fifo_level,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic          ovf_sticky,
    output logic          frm_err_sticky,
    output logic [7:0]    err_cnt,
    input  logic          sts_clr,
    output logic          irq
`ifdef UART_RX_CTRL_TIMEOUT_EN
    ,
    output logic          timeout_flag
`endif
);

    typedef enum logic [1:0] {S_OFF, S_IDLE, S_RX, S_STALL} state_t;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            rx_en_q, rx_en_d;
    logic            rd_valid_q, rd_valid_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic            ovf_q, ovf_d, frm_q, frm_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            irq_q, irq_d;
    logic            err_dly_q, err_dly_d;
    logic [7:0]      mem_q [DEPTH];

    logic push_req, pop_ok, push_ok, ovf_set, err_rise, is_full, rx_exit;

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYC);
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_q, tmo_d, tmo_reload;
`endif

    always_comb begin
        is_full  = (level_q == FULL_LVL);
        push_req = core_rx_done && (state_q != S_OFF);
        pop_ok   = rd_req && (level_q != '0) && !cfg_flush;
        // a full FIFO still accepts a byte when a pop frees a slot in the same cycle
        push_ok  = push_req && (!is_full || pop_ok) && !cfg_flush;
        ovf_set  = push_req && is_full && !pop_ok && !cfg_flush;
        err_rise = core_rx_error && !err_dly_q;
        rx_exit  = core_rx_done || err_rise || !core_rx_busy;

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = pop_ok;
        err_dly_d  = core_rx_error;

        if (cfg_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok) begin
                rd_ptr_d  = rd_ptr_q + 1'b1;
                rd_data_d = mem_q[rd_ptr_q];
            end
            level_d = level_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end

        ovf_d = ovf_set ? 1'b1 : (sts_clr ? 1'b0 : ovf_q);
        frm_d = err_rise ? 1'b1 : (sts_clr ? 1'b0 : frm_q);
        if (err_rise)
            err_cnt_d = sts_clr ? 8'd1 : ((err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1);
        else
            err_cnt_d = sts_clr ? 8'd0 : err_cnt_q;

        state_d = state_q;
        case (state_q)
            S_OFF:   if (cfg_en) state_d = S_IDLE;
            S_IDLE: begin
                if (core_rx_busy) state_d = S_RX;
                else if (!cfg_en) state_d = S_OFF;
            end
            S_RX: begin
                if (rx_exit) begin
                    if (!cfg_en) state_d = S_OFF;
                    else if (STALL_ON_FULL && (level_d == FULL_LVL)) state_d = S_STALL;
                    else state_d = S_IDLE;
                end
            end
            S_STALL: begin
                if (!cfg_en) state_d = S_OFF;
                else if (!is_full) state_d = S_IDLE;
            end
            default: state_d = S_OFF;
        endcase

        rx_en_d = (state_q == S_IDLE) || (state_q == S_RX);

`ifdef UART_RX_CTRL_TIMEOUT_EN
        tmo_reload = push_ok || pop_ok || cfg_flush || (state_q != S_IDLE) || (level_q == '0);
        tmo_cnt_d  = tmo_cnt_q;
        if (tmo_reload) tmo_cnt_d = TMO_LOAD;
        else if (tmo_cnt_q != '0) tmo_cnt_d = tmo_cnt_q - 32'd1;
        if (!tmo_reload && (tmo_cnt_q == 32'd1)) tmo_d = 1'b1;
        else if (sts_clr || pop_ok) tmo_d = 1'b0;
        else tmo_d = tmo_q;
        irq_d = ((cfg_thresh != '0) && (level_q >= cfg_thresh)) || ovf_q || frm_q || tmo_q;
`else
        irq_d = ((cfg_thresh != '0) && (level_q >= cfg_thresh)) || ovf_q || frm_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_OFF;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rx_en_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            ovf_q      <= 1'b0;
            frm_q      <= 1'b0;
            err_cnt_q  <= '0;
            irq_q      <= 1'b0;
            err_dly_q  <= 1'b0;
`ifdef UART_RX_CTRL_TIMEOUT_EN
            tmo_cnt_q  <= TMO_LOAD;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rx_en_q    <= rx_en_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            ovf_q      <= ovf_d;
            frm_q      <= frm_d;
            err_cnt_q  <= err_cnt_d;
            irq_q      <= irq_d;
            err_dly_q  <= err_dly_d;
`ifdef UART_RX_CTRL_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

    // storage needs no reset: a slot is only read after it has been written
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= core_rx_data;
    end

    assign core_rx_en     = rx_en_q;
    assign rd_data        = rd_data_q;
    assign rd_valid       = rd_valid_q;
    assign fifo_level     = level_q;
    assign fifo_empty     = (level_q == '0);
    assign fifo_full      = (level_q == FULL_LVL);
    assign ovf_sticky     = ovf_q;
    assign frm_err_sticky = frm_q;
    assign err_cnt        = err_cnt_q;
    assign irq            = irq_q;
`ifdef UART_RX_CTRL_TIMEOUT_EN
    assign timeout_flag   = tmo_q;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: one stalling and one non-stalling instance on shared stimulus,
// compared every cycle against a queue-style behavioural model plus directed checks.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int M_OFF = 0, M_IDLE = 1, M_RX = 2, M_STALL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, cfg_en, cfg_flush, core_rx_busy, core_rx_done, core_rx_error, rd_req, sts_clr;
    logic [AW:0]   cfg_thresh;
    logic [7:0]    core_rx_data;
    logic          en_o [2], rdv_o [2], full_o [2], empty_o [2], ovf_o [2], frm_o [2], irq_o [2];
    logic [7:0]    rdd_o [2], ecnt_o [2];
    logic [AW:0]   lvl_o [2];

    uart_rx_ctrl #(.DEPTH(DEPTH), .AW(AW), .STALL_ON_FULL(1'b1)) u_stall (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_flush(cfg_flush), .cfg_thresh(cfg_thresh),
        .core_rx_en(en_o[0]), .core_rx_busy(core_rx_busy), .core_rx_done(core_rx_done),
        .core_rx_error(core_rx_error), .core_rx_data(core_rx_data), .rd_req(rd_req),
        .rd_data(rdd_o[0]), .rd_valid(rdv_o[0]), .fifo_level(lvl_o[0]), .fifo_empty(empty_o[0]),
        .fifo_full(full_o[0]), .ovf_sticky(ovf_o[0]), .frm_err_sticky(frm_o[0]),
        .err_cnt(ecnt_o[0]), .sts_clr(sts_clr), .irq(irq_o[0]));

    uart_rx_ctrl #(.DEPTH(DEPTH), .AW(AW), .STALL_ON_FULL(1'b0)) u_nostall (
        .clk(clk), .rst(rst), .cfg_en(cfg_en), .cfg_flush(cfg_flush), .cfg_thresh(cfg_thresh),
        .core_rx_en(en_o[1]), .core_rx_busy(core_rx_busy), .core_rx_done(core_rx_done),
        .core_rx_error(core_rx_error), .core_rx_data(core_rx_data), .rd_req(rd_req),
        .rd_data(rdd_o[1]), .rd_valid(rdv_o[1]), .fifo_level(lvl_o[1]), .fifo_empty(empty_o[1]),
        .fifo_full(full_o[1]), .ovf_sticky(ovf_o[1]), .frm_err_sticky(frm_o[1]),
        .err_cnt(ecnt_o[1]), .sts_clr(sts_clr), .irq(irq_o[1]));

    int checks = 0;
    int failures = 0;

    // reference model: circular buffer described by head index and count
    int         m_st [2], m_cnt [2], m_head [2], m_ecnt [2];
    logic [7:0] m_mem [2][DEPTH];
    logic [7:0] m_rdd [2];
    bit         m_rdv [2], m_en [2], m_ovf [2], m_frm [2], m_irq [2];
    bit         m_eprev;

    task automatic model_step();
        bit rise;
        rise = core_rx_error && !m_eprev;
        for (int k = 0; k < 2; k++) begin
            int c0, h0, st0, newcnt;
            bit pop, push_req, pushed, ovf_set, exit_rx;
            c0 = m_cnt[k]; h0 = m_head[k]; st0 = m_st[k];
            if (rst) begin
                m_st[k] = M_OFF; m_cnt[k] = 0; m_head[k] = 0; m_ecnt[k] = 0; m_rdd[k] = 8'h00;
                m_rdv[k] = 0; m_en[k] = 0; m_ovf[k] = 0; m_frm[k] = 0; m_irq[k] = 0;
            end else begin
                m_irq[k] = ((cfg_thresh != 0) && (c0 >= int'(cfg_thresh))) || m_ovf[k] || m_frm[k];
                m_en[k]  = (st0 == M_IDLE) || (st0 == M_RX);
                push_req = core_rx_done && (st0 != M_OFF);
                pop = 0; pushed = 0; ovf_set = 0;
                if (cfg_flush) begin
                    newcnt = 0; m_head[k] = 0;
                end else begin
                    pop = rd_req && (c0 > 0);
                    if (pop) begin
                        m_rdd[k]  = m_mem[k][h0];
                        m_head[k] = (h0 + 1) % DEPTH;
                    end
                    if (push_req) begin
                        if (c0 < DEPTH || pop) begin
                            m_mem[k][(h0 + c0) % DEPTH] = core_rx_data;
                            pushed = 1;
                        end else ovf_set = 1;
                    end
                    newcnt = c0 + int'(pushed) - int'(pop);
                end
                m_cnt[k] = newcnt;
                m_rdv[k] = pop;
                m_ovf[k] = ovf_set ? 1'b1 : (sts_clr ? 1'b0 : m_ovf[k]);
                m_frm[k] = rise ? 1'b1 : (sts_clr ? 1'b0 : m_frm[k]);
                if (rise) m_ecnt[k] = sts_clr ? 1 : ((m_ecnt[k] >= 255) ? 255 : m_ecnt[k] + 1);
                else if (sts_clr) m_ecnt[k] = 0;
                exit_rx = core_rx_done || rise || !core_rx_busy;
                case (st0)
                    M_OFF:   if (cfg_en) m_st[k] = M_IDLE;
                    M_IDLE:  if (core_rx_busy) m_st[k] = M_RX; else if (!cfg_en) m_st[k] = M_OFF;
                    M_RX:    if (exit_rx) m_st[k] = !cfg_en ? M_OFF : ((k == 0 && newcnt == DEPTH) ? M_STALL : M_IDLE);
                    default: if (!cfg_en) m_st[k] = M_OFF; else if (c0 < DEPTH) m_st[k] = M_IDLE;
                endcase
            end
        end
        m_eprev = rst ? 1'b0 : core_rx_error;
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic [27:0] exp_v, act_v;
            exp_v = {m_en[k], m_rdv[k], m_rdd[k], 5'(m_cnt[k]), (m_cnt[k] == 0), (m_cnt[k] == DEPTH),
                     m_ovf[k], m_frm[k], 8'(m_ecnt[k]), m_irq[k]};
            act_v = {en_o[k], rdv_o[k], rdd_o[k], lvl_o[k], empty_o[k], full_o[k],
                     ovf_o[k], frm_o[k], ecnt_o[k], irq_o[k]};
            checks++;
            if (act_v !== exp_v) begin
                failures++;
                $display("FAIL model_inst%0d t=%0t act=%h exp=%h", k, $time, act_v, exp_v);
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d", name, act, exp_v);
        end
    endtask

    task automatic frame(input logic [7:0] d);
        core_rx_busy = 1; tick();
        core_rx_busy = 0; core_rx_done = 1; core_rx_data = d; tick();
        core_rx_done = 0;
    endtask

    typedef struct packed {
        bit       en;
        bit       done;
        logic [7:0] data;
        bit       rd;
        int       lvl;
        bit       rdv;
        logic [7:0] rdd;
        bit       rxen;
    } vec_t;
    vec_t tv [8];

    initial begin
        tv[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b0};
        tv[1] = '{1'b1, 1'b1, 8'h55, 1'b0, 1, 1'b0, 8'h00, 1'b1};
        tv[2] = '{1'b1, 1'b1, 8'hA3, 1'b0, 2, 1'b0, 8'h00, 1'b1};
        tv[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 2, 1'b0, 8'h00, 1'b1};
        tv[4] = '{1'b1, 1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h55, 1'b1};
        tv[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1, 1'b0, 8'h55, 1'b1};
        tv[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b1, 8'hA3, 1'b1};
        tv[7] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'hA3, 1'b1};

        for (int k = 0; k < 2; k++) begin
            m_st[k] = M_OFF; m_cnt[k] = 0; m_head[k] = 0; m_ecnt[k] = 0; m_rdd[k] = 8'h00;
            m_rdv[k] = 0; m_en[k] = 0; m_ovf[k] = 0; m_frm[k] = 0; m_irq[k] = 0;
        end
        m_eprev = 0;

        rst = 1; cfg_en = 0; cfg_flush = 0; cfg_thresh = '0; core_rx_busy = 0; core_rx_done = 0;
        core_rx_error = 0; core_rx_data = 8'h00; rd_req = 0; sts_clr = 0;
        #2;
        tick(); tick();
        chk("reset_rx_en", int'(en_o[0]), 0);
        chk("reset_rd_data", int'(rdd_o[0]), 0);
        chk("reset_irq", int'(irq_o[1]), 0);
        chk("reset_empty", int'(empty_o[0]), 1);
        rst = 0;

        // two bytes in, two out, then a pop on empty
        for (int i = 0; i < 8; i++) begin
            cfg_en = tv[i].en; core_rx_done = tv[i].done; core_rx_data = tv[i].data; rd_req = tv[i].rd;
            tick();
            chk($sformatf("tv%0d_level", i), int'(lvl_o[0]), tv[i].lvl);
            chk($sformatf("tv%0d_rd_valid", i), int'(rdv_o[0]), int'(tv[i].rdv));
            chk($sformatf("tv%0d_rd_data", i), int'(rdd_o[0]), int'(tv[i].rdd));
            chk($sformatf("tv%0d_rx_en", i), int'(en_o[0]), int'(tv[i].rxen));
        end
        core_rx_done = 0; rd_req = 0;
        chk("tv_empty", int'(empty_o[0]), 1);

        // stall on full
        for (int i = 0; i < DEPTH; i++) frame(8'(i + 8'h10));
        chk("stall_full", int'(full_o[0]), 1);
        tick();
        chk("stall_rx_en_low", int'(en_o[0]), 0);
        chk("nostall_rx_en_high", int'(en_o[1]), 1);
        rd_req = 1; tick(); rd_req = 0;
        tick(); tick();
        chk("stall_rx_en_back", int'(en_o[0]), 1);
        chk("stall_no_ovf", int'(ovf_o[0]), 0);

        // overflow on the non-stalling instance
        core_rx_done = 1; core_rx_data = 8'hC1; tick();
        core_rx_data = 8'hC2; tick();
        core_rx_done = 0;
        chk("ovf_set", int'(ovf_o[1]), 1);
        chk("ovf_level", int'(lvl_o[1]), DEPTH);
        tick();
        chk("ovf_irq", int'(irq_o[1]), 1);
        sts_clr = 1; tick(); sts_clr = 0;
        chk("ovf_clr", int'(ovf_o[1]), 0);
        tick();
        chk("ovf_irq_clr", int'(irq_o[1]), 0);
        cfg_flush = 1; tick(); cfg_flush = 0;

        // framing errors held two cycles
        for (int i = 0; i < 3; i++) begin
            core_rx_error = 1; tick(); tick();
            core_rx_error = 0; tick();
        end
        chk("err_cnt3", int'(ecnt_o[1]), 3);
        chk("frm_sticky", int'(frm_o[1]), 1);
        chk("err_no_push", int'(lvl_o[1]), 0);
        core_rx_error = 1; sts_clr = 1; tick();
        sts_clr = 0; core_rx_error = 0;
        chk("err_clr_collide", int'(ecnt_o[0]), 1);
        tick();
        for (int i = 0; i < 256; i++) begin
            core_rx_error = 1; tick();
            core_rx_error = 0; tick();
        end
        chk("err_saturate", int'(ecnt_o[0]), 255);
        sts_clr = 1; tick(); sts_clr = 0;
        chk("err_cleared", int'(ecnt_o[0]), 0);
        tick();

        // level threshold and flush priority
        cfg_thresh = 5'd4;
        for (int i = 0; i < 4; i++) begin
            core_rx_done = 1; core_rx_data = 8'(8'hE0 + i); tick();
        end
        core_rx_done = 0; tick();
        chk("thresh_irq", int'(irq_o[0]), 1);
        cfg_flush = 1; core_rx_done = 1; core_rx_data = 8'h99; rd_req = 1; tick();
        cfg_flush = 0; core_rx_done = 0; rd_req = 0;
        chk("flush_level", int'(lvl_o[0]), 0);
        chk("flush_rd_valid", int'(rdv_o[0]), 0);
        tick();
        chk("flush_irq", int'(irq_o[0]), 0);
        cfg_thresh = '0;

        // disable during a frame: frame completes and is stored
        core_rx_busy = 1; tick();
        cfg_en = 0; tick(); tick();
        chk("dis_rx_en_held", int'(en_o[0]), 1);
        core_rx_done = 1; core_rx_data = 8'h7E; core_rx_busy = 0; tick();
        core_rx_done = 0;
        chk("dis_level", int'(lvl_o[0]), 1);
        tick();
        chk("dis_rx_en_off", int'(en_o[0]), 0);
        rd_req = 1; tick(); rd_req = 0;
        chk("dis_rd_data", int'(rdd_o[0]), 8'h7E);

        // randomized traffic against the model
        cfg_en = 1;
        for (int i = 0; i < 4000; i++) begin
            rst           = ($urandom_range(0, 599) == 0);
            cfg_en        = ($urandom_range(0, 15) != 0);
            cfg_flush     = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0) core_rx_busy = ~core_rx_busy;
            core_rx_done  = ($urandom_range(0, 2) == 0);
            core_rx_data  = 8'($urandom);
            if ($urandom_range(0, 5) == 0) core_rx_error = ~core_rx_error;
            rd_req        = ($urandom_range(0, 4) == 0);
            sts_clr       = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) cfg_thresh = 5'($urandom_range(0, 16));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
